// File: rtl/z180_bus_pkg.sv
// Shared types and widths for the Z8S180 external-bus master.
// The width constants are also used by the top-level address decoders.
package z180_bus_pkg;

    localparam int Z180_A_W = 20;
    localparam int Z180_D_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_TW   = 3'd4,
        ST_T3   = 3'd5,
        ST_REL  = 3'd6
    } z180_state_e;

    typedef struct packed {
        logic                we;
        logic [Z180_A_W-1:0] addr;
        logic [Z180_D_W-1:0] wdata;
    } z180_req_t;

    // /BUSREQ is held from arbitration through the last T3 of a tenure.
    function automatic logic owns_bus(z180_state_e s);
        return (s inside {ST_ARB, ST_T1, ST_T2, ST_TW, ST_T3});
    endfunction

endpackage

// File: rtl/z180_bus_master_if.sv
// Client handshake and Z8S180 bus pins of the bus master.
// master = the bus master itself, slave = client plus CPU/SRAM side.
interface z180_bus_master_if;
    import z180_bus_pkg::*;

    logic                req;
    logic                req_we;
    logic [Z180_A_W-1:0] req_addr;
    logic [Z180_D_W-1:0] req_wdata;
    logic                ready;
    logic                done;
    logic [Z180_D_W-1:0] rdata;
    logic                err;
    logic                busreq_n;
    logic                busack_n;
    logic [Z180_A_W-1:0] a_out;
    logic                a_oe;
    logic [Z180_D_W-1:0] d_in;
    logic [Z180_D_W-1:0] d_out;
    logic                d_oe;
    logic                mreq_n_out;
    logic                rd_n_out;
    logic                wr_n_out;
    logic                busy;

    modport master (
        input  req, req_we, req_addr, req_wdata, busack_n, d_in,
        output ready, done, rdata, err, busreq_n, a_out, a_oe,
        output d_out, d_oe, mreq_n_out, rd_n_out, wr_n_out, busy
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, busack_n, d_in,
        input  ready, done, rdata, err, busreq_n, a_out, a_oe,
        input  d_out, d_oe, mreq_n_out, rd_n_out, wr_n_out, busy
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/z180_bus_master.sv
// Z8S180 bus initiator: /BUSREQ arbitration, then phi-timed SRAM cycles.
// Define Z180_BUS_MASTER_TIMEOUT_EN to abort arbitration after TIMEOUT_CYC.
module z180_bus_master
    import z180_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int HOLD_MAX    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              phi,
    input  logic              reset,
    z180_bus_master_if.master bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 7 ||
        HOLD_MAX < 1 || HOLD_MAX > 255 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("z180_bus_master: parameter out of range");
    end

    localparam logic [2:0] WS_L   = 3'(WAIT_STATES);
    localparam logic [8:0] HOLD_L = 9'(HOLD_MAX);

    z180_state_e           state_q;
    z180_state_e           state_d;
    z180_req_t             req_q;
    logic [7:0]            xfer_cnt_q;
    logic [2:0]            wcnt_q;
    logic                  done_q;
    logic [Z180_D_W-1:0]   rdata_q;
    logic                  busack_s;
    logic                  gnt;
    logic                  ready;
    logic                  accept;
    logic                  timeout;

    logic busreq_n;
    logic a_oe;
    logic d_oe;
    logic mreq_n;
    logic rd_n;
    logic wr_n;

    sync2 #(.RST_VAL(1'b1)) u_busack_sync (
        .clk_i (phi),
        .rst_i (reset),
        .d_i   (bus.busack_n),
        .q_o   (busack_s)
    );

    assign gnt = ~busack_s;

`ifdef Z180_BUS_MASTER_TIMEOUT_EN
    localparam int ARB_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ARB_W-1:0] ARB_LAST = ARB_W'(TIMEOUT_CYC - 1);

    logic [ARB_W-1:0] arb_cnt_q;

    always_ff @(posedge phi) begin
        if (reset || state_q != ST_ARB) begin
            arb_cnt_q <= '0;
        end else begin
            arb_cnt_q <= arb_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ST_ARB) && !gnt && (arb_cnt_q == ARB_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Tenure limit: a further back-to-back request is refused on the last slot.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_T3:   ready = ({1'b0, xfer_cnt_q} + 9'd1) < HOLD_L;
            default: ready = 1'b0;
        endcase
    end

    assign accept = bus.req && ready;

    always_ff @(posedge phi) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_ARB;
            ST_ARB: begin
                if (gnt)          state_d = ST_T1;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = (WS_L != 3'd0) ? ST_TW : ST_T3;
            ST_TW:   if (wcnt_q <= 3'd1) state_d = ST_T3;
            ST_T3:   state_d = accept ? ST_T1 : ST_REL;
            ST_REL:  if (!gnt) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busreq_n = ~owns_bus(state_q);
        a_oe     = 1'b0;
        d_oe     = 1'b0;
        mreq_n   = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        unique case (state_q)
            ST_T1: begin
                a_oe = 1'b1;
                d_oe = req_q.we;
            end
            ST_T2, ST_TW, ST_T3: begin
                a_oe   = 1'b1;
                d_oe   = req_q.we;
                mreq_n = 1'b0;
                rd_n   = req_q.we;
                wr_n   = ~req_q.we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge phi) begin
        if (reset) begin
            req_q      <= '0;
            xfer_cnt_q <= '0;
            wcnt_q     <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            done_q <= (state_q == ST_T3);
            if (accept) begin
                req_q <= '{we: bus.req_we, addr: bus.req_addr,
                           wdata: bus.req_wdata};
            end
            if (state_q == ST_IDLE && accept) begin
                xfer_cnt_q <= '0;
            end else if (state_q == ST_T3 && xfer_cnt_q != 8'hFF) begin
                xfer_cnt_q <= xfer_cnt_q + 8'd1;
            end
            if (state_q == ST_T2) begin
                wcnt_q <= WS_L;
            end else if (state_q == ST_TW) begin
                wcnt_q <= wcnt_q - 3'd1;
            end
            if (state_q == ST_T3 && !req_q.we) begin
                rdata_q <= bus.d_in;
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.err        = timeout;
    assign bus.busreq_n   = busreq_n;
    assign bus.a_out      = req_q.addr;
    assign bus.a_oe       = a_oe;
    assign bus.d_out      = req_q.wdata;
    assign bus.d_oe       = d_oe;
    assign bus.mreq_n_out = mreq_n;
    assign bus.rd_n_out   = rd_n;
    assign bus.wr_n_out   = wr_n;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_z180_bus_master.sv
// Directed bench for z180_bus_master with a simple CPU grant/SRAM model.
// Define Z180_BUS_MASTER_TIMEOUT_EN to include the arbitration-timeout step.
module tb_z180_bus_master;

    localparam int WS      = 1;
    localparam int HM      = 4;
    localparam int TO      = 16;
    localparam int GNT_DLY = 3;

    logic phi   = 1'b0;
    logic reset = 1'b1;

    z180_bus_master_if bus ();

    z180_bus_master #(
        .WAIT_STATES (WS),
        .HOLD_MAX    (HM),
        .TIMEOUT_CYC (TO)
    ) dut (
        .phi   (phi),
        .reset (reset),
        .bus   (bus)
    );

    always #5 phi = ~phi;

    int checks = 0;
    int errors = 0;

    // CPU side: grant GNT_DLY negedges after /BUSREQ falls, release at once
    bit grant_en = 1'b1;
    int gdly     = 0;
    always @(negedge phi) begin
        if (bus.busreq_n === 1'b0 && grant_en) begin
            if (gdly >= GNT_DLY - 1) bus.busack_n = 1'b0;
            else gdly++;
        end else begin
            bus.busack_n = 1'b1;
            gdly = 0;
        end
    end

    int          done_cnt = 0;
    int          wr_low   = 0;
    int          rd_low   = 0;
    int          dout_bad = 0;
    int          aout_bad = 0;
    int          doe_bad  = 0;
    int          rel_cnt  = 0;
    int          rdy_t3   = 0;
    int          rel_snap[$];
    logic [7:0]  exp_dout    = 8'h00;
    logic [7:0]  last_rdata  = 8'h00;
    logic        prev_busreq = 1'b1;
    logic [19:0] prev_aout   = '0;

    always @(negedge phi) begin
        if (!reset) begin
            if (!bus.wr_n_out) wr_low++;
            if (!bus.rd_n_out) rd_low++;
            if (bus.done) begin
                done_cnt++;
                last_rdata = bus.rdata;
            end
            if (bus.d_oe && bus.d_out !== exp_dout) dout_bad++;
            if (!bus.mreq_n_out && bus.a_out !== prev_aout) aout_bad++;
            if (!bus.mreq_n_out && !bus.a_oe) aout_bad++;
            if (!bus.wr_n_out && !bus.d_oe) doe_bad++;
            if (!bus.mreq_n_out && bus.ready) rdy_t3++;
            if (prev_busreq === 1'b0 && bus.busreq_n === 1'b1) begin
                rel_cnt++;
                rel_snap.push_back(done_cnt);
            end
        end
        prev_busreq = bus.busreq_n;
        prev_aout   = bus.a_out;
    end

    task automatic tick();
        @(posedge phi);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic start(input logic we, input logic [19:0] a,
                         input logic [7:0] wd);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    int base_done, base_wr, base_rd, base_rel, base_rdy;
    int n, acc, first_rel_done;

    initial begin
        bus.req       = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.d_in      = 8'h3C;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busreq_n", 32'(bus.busreq_n), 32'd1);
        chk("rst_a_oe", 32'(bus.a_oe), 32'd0);
        chk("rst_d_oe", 32'(bus.d_oe), 32'd0);
        chk("rst_mreq_n", 32'(bus.mreq_n_out), 32'd1);
        chk("rst_rd_n", 32'(bus.rd_n_out), 32'd1);
        chk("rst_wr_n", 32'(bus.wr_n_out), 32'd1);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();

        // single write
        base_done = done_cnt; base_wr = wr_low;
        base_rd = rd_low; base_rel = rel_cnt;
        exp_dout = 8'hA5;
        start(1'b1, 20'h01234, 8'hA5);
        tick();
        bus.req = 1'b0;
        chk("wr_arb_busreq_n", 32'(bus.busreq_n), 32'd0);
        chk("wr_arb_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.a_oe !== 1'b1 && n < 40) begin tick(); n++; end
        chk("wr_t1_reached", 32'(bus.a_oe), 32'd1);
        chk("wr_t1_addr", 32'(bus.a_out), 32'h01234);
        chk("wr_t1_d_oe", 32'(bus.d_oe), 32'd1);
        chk("wr_t1_d_out", 32'(bus.d_out), 32'hA5);
        chk("wr_t1_mreq_n", 32'(bus.mreq_n_out), 32'd1);
        wait_idle("wr_idle");
        chk("wr_strobe_len", 32'(wr_low - base_wr), 32'(1 + WS + 1));
        chk("wr_no_rd", 32'(rd_low - base_rd), 32'd0);
        chk("wr_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("wr_released", 32'(rel_cnt - base_rel), 32'd1);
        chk("wr_busreq_n", 32'(bus.busreq_n), 32'd1);

        // single read
        base_done = done_cnt; base_wr = wr_low;
        base_rd = rd_low; base_rel = rel_cnt;
        start(1'b0, 20'hFFFFF, 8'h00);
        tick();
        bus.req = 1'b0;
        n = 0;
        while (bus.a_oe !== 1'b1 && n < 40) begin tick(); n++; end
        chk("rd_t1_addr", 32'(bus.a_out), 32'hFFFFF);
        chk("rd_t1_d_oe", 32'(bus.d_oe), 32'd0);
        wait_idle("rd_idle");
        chk("rd_strobe_len", 32'(rd_low - base_rd), 32'(1 + WS + 1));
        chk("rd_no_wr", 32'(wr_low - base_wr), 32'd0);
        chk("rd_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("rd_data_at_done", 32'(last_rdata), 32'h3C);
        chk("rd_data_held", 32'(bus.rdata), 32'h3C);

        // burst of 6 writes, tenure limited to HM transfers
        base_done = done_cnt; base_rel = rel_cnt; base_rdy = rdy_t3;
        exp_dout = 8'h5A;
        start(1'b1, 20'h00400, 8'h5A);
        acc = 0;
        for (int c = 0; c < 300 && acc < 6; c++) begin
            if (bus.ready === 1'b1) acc++;
            tick();
        end
        bus.req = 1'b0;
        chk("burst_accepts", 32'(acc), 32'd6);
        wait_idle("burst_idle");
        chk("burst_dones", 32'(done_cnt - base_done), 32'd6);
        chk("burst_tenures", 32'(rel_cnt - base_rel), 32'd2);
        first_rel_done = (rel_snap.size() >= 2) ?
                         rel_snap[rel_snap.size() - 2] - base_done : -1;
        chk("burst_first_tenure", 32'(first_rel_done), 32'(HM));
        chk("burst_ready_in_t3", 32'(rdy_t3 - base_rdy), 32'd5);
        chk("dout_stable", 32'(dout_bad), 32'd0);
        chk("addr_stable", 32'(aout_bad), 32'd0);
        chk("doe_covers_wr", 32'(doe_bad), 32'd0);

        // reset during TW of a write
        base_done = done_cnt;
        start(1'b1, 20'h0ABCD, 8'h5A);
        tick();
        bus.req = 1'b0;
        n = 0;
        while (bus.mreq_n_out !== 1'b0 && n < 40) begin tick(); n++; end
        chk("tw_t2_reached", 32'(bus.mreq_n_out), 32'd0);
        tick();
        chk("tw_wr_n_low", 32'(bus.wr_n_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("tw_rst_mreq_n", 32'(bus.mreq_n_out), 32'd1);
        chk("tw_rst_wr_n", 32'(bus.wr_n_out), 32'd1);
        chk("tw_rst_a_oe", 32'(bus.a_oe), 32'd0);
        chk("tw_rst_d_oe", 32'(bus.d_oe), 32'd0);
        chk("tw_rst_busreq_n", 32'(bus.busreq_n), 32'd1);
        chk("tw_rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("tw_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("tw_idle", 32'(bus.busy), 32'd0);

`ifdef Z180_BUS_MASTER_TIMEOUT_EN
        grant_en = 1'b0;
        base_done = done_cnt;
        start(1'b0, 20'h00010, 8'h00);
        tick();
        bus.req = 1'b0;
        n = 1;
        while (bus.err !== 1'b1 && n < 60) begin tick(); n++; end
        chk("to_err_cycle", 32'(n), 32'(TO));
        tick();
        chk("to_err_pulse", 32'(bus.err), 32'd0);
        chk("to_idle", 32'(bus.busy), 32'd0);
        chk("to_busreq_n", 32'(bus.busreq_n), 32'd1);
        chk("to_no_done", 32'(done_cnt - base_done), 32'd0);
        grant_en = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
